// File: rtl/shield_burst_read_mstr.sv
// AXI read burst master: converts line-granular read requests into one or two
// INCR bursts (split at 4 KB) and returns beats with per-line addresses.
module shield_burst_read_mstr #(
    parameter int DATA_W  = 512,
    parameter int ADDR_W  = 64,
    parameter int ID_W    = 16,
    parameter int MAX_LEN = 16,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [$clog2(MAX_LEN+1)-1:0] req_len,
    input  logic                         req_val,
    output logic                         req_rdy,
    output logic [ADDR_W-1:0]            resp_addr,
    output logic [DATA_W-1:0]            resp_data,
    output logic                         resp_last,
    output logic                         resp_err,
    output logic                         resp_val,
    input  logic                         resp_rdy,
    output logic                         err_seen,
    output logic [ID_W-1:0]              m_axi_arid,
    output logic [ADDR_W-1:0]            m_axi_araddr,
    output logic [7:0]                   m_axi_arlen,
    output logic [2:0]                   m_axi_arsize,
    output logic [1:0]                   m_axi_arburst,
    output logic                         m_axi_arlock,
    output logic [3:0]                   m_axi_arcache,
    output logic [2:0]                   m_axi_arprot,
    output logic [3:0]                   m_axi_arqos,
    output logic [3:0]                   m_axi_arregion,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    input  logic [ID_W-1:0]              m_axi_rid,
    input  logic [DATA_W-1:0]            m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp,
    input  logic                         m_axi_rlast,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready
);
    localparam int LINE_B   = DATA_W / 8;
    localparam int OFF_W    = $clog2(LINE_B);
    localparam int LEN_W    = $clog2(MAX_LEN + 1);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int PG_LINES = 4096 / LINE_B;

    typedef enum logic [1:0] {IDLE, AR0, AR1} state_t;

    state_t              state_q;
    logic                arvalid_q;
    logic [ADDR_W-1:0]   araddr_q;
    logic [ADDR_W-1:0]   addr2_q;
    logic [7:0]          arlen_q;
    logic [7:0]          arlen2_q;
    logic                split_q;

    logic [ADDR_W-1:0]   trk_addr_q [DEPTH];
    logic [DEPTH-1:0]    trk_last_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [7:0]          beat_cnt_q;
    logic                err_seen_q;

    logic [ADDR_W-1:0]   base_d;
    logic [15:0]         n_d;
    logic [15:0]         rem_d;
    logic [15:0]         n0_d;
    logic                ar_hs;
    logic                r_hs;
    logic                push;
    logic                pop;
    logic                push_last;
    logic                trk_empty;
    logic                unused_rid;

    always_comb begin
        base_d = req_addr & ~ADDR_W'(LINE_B - 1);
        if (req_len == '0)
            n_d = 16'd1;
        else if (req_len > LEN_W'(MAX_LEN))
            n_d = 16'(MAX_LEN);
        else
            n_d = 16'(req_len);
        // lines left before the next 4 KB boundary
        rem_d = 16'(PG_LINES) - 16'(base_d[11:0] >> OFF_W);
        n0_d  = (n_d < rem_d) ? n_d : rem_d;
    end

    assign trk_empty = (count_q == '0);
    assign req_rdy   = rst_n && (state_q == IDLE) && (count_q <= CNT_W'(DEPTH - 2));
    assign ar_hs     = arvalid_q && m_axi_arready;
    assign r_hs      = m_axi_rvalid && m_axi_rready;
    assign push      = ar_hs;
    assign push_last = (state_q == AR1) || !split_q;
    assign pop       = r_hs && m_axi_rlast;

    assign m_axi_arid     = '0;
    assign m_axi_arsize   = 3'(OFF_W);
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'd0;
    assign m_axi_arprot   = 3'd0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_araddr   = araddr_q;
    assign m_axi_arlen    = arlen_q;
    assign m_axi_arvalid  = arvalid_q;

    assign resp_val     = m_axi_rvalid && !trk_empty;
    assign m_axi_rready = resp_rdy && !trk_empty;
    assign resp_data    = m_axi_rdata;
    assign resp_err     = (m_axi_rresp != 2'b00);
    assign resp_last    = m_axi_rlast && trk_last_q[rd_ptr_q];
    assign resp_addr    = trk_addr_q[rd_ptr_q] + (ADDR_W'(beat_cnt_q) << OFF_W);
    assign err_seen     = err_seen_q;
    assign unused_rid   = ^m_axi_rid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            addr2_q   <= '0;
            arlen_q   <= '0;
            arlen2_q  <= '0;
            split_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_val && req_rdy) begin
                    state_q   <= AR0;
                    arvalid_q <= 1'b1;
                    araddr_q  <= base_d;
                    arlen_q   <= 8'(n0_d - 16'd1);
                    split_q   <= (n0_d != n_d);
                    addr2_q   <= base_d + (ADDR_W'(n0_d) << OFF_W);
                    arlen2_q  <= 8'(n_d - n0_d - 16'd1);
                end
                AR0: if (m_axi_arready) begin
                    if (split_q) begin
                        state_q  <= AR1;
                        araddr_q <= addr2_q;
                        arlen_q  <= arlen2_q;
                    end else begin
                        state_q   <= IDLE;
                        arvalid_q <= 1'b0;
                    end
                end
                AR1: if (m_axi_arready) begin
                    state_q   <= IDLE;
                    arvalid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            trk_last_q <= '0;
            beat_cnt_q <= '0;
            err_seen_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q             <= wr_ptr_q + 1'b1;
                trk_last_q[wr_ptr_q] <= push_last;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
            if (r_hs)
                beat_cnt_q <= m_axi_rlast ? 8'd0 : beat_cnt_q + 8'd1;
            if (r_hs && resp_err)
                err_seen_q <= 1'b1;
        end
    end

    // address payload needs no reset; validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (push)
            trk_addr_q[wr_ptr_q] <= araddr_q;
    end

endmodule

// File: tb/tb_shield_burst_read_mstr.sv
// Scoreboard bench for shield_burst_read_mstr with a simple in-order AXI read slave.
module tb_shield_burst_read_mstr;
    localparam int DATA_W  = 512;
    localparam int ADDR_W  = 64;
    localparam int ID_W    = 16;
    localparam int MAX_LEN = 16;
    localparam int DEPTH   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] req_addr = '0;
    logic [LEN_W-1:0]  req_len = '0;
    logic              req_val = 1'b0;
    logic              req_rdy;
    logic [ADDR_W-1:0] resp_addr;
    logic [DATA_W-1:0] resp_data;
    logic              resp_last, resp_err, resp_val;
    logic              resp_rdy;
    logic              err_seen;
    logic [ID_W-1:0]   m_axi_arid;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arlock;
    logic [3:0]        m_axi_arcache;
    logic [2:0]        m_axi_arprot;
    logic [3:0]        m_axi_arqos;
    logic [3:0]        m_axi_arregion;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [ID_W-1:0]   m_axi_rid;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast, m_axi_rvalid, m_axi_rready;

    shield_burst_read_mstr #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_LEN(MAX_LEN), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_addr(req_addr), .req_len(req_len), .req_val(req_val), .req_rdy(req_rdy),
        .resp_addr(resp_addr), .resp_data(resp_data), .resp_last(resp_last),
        .resp_err(resp_err), .resp_val(resp_val), .resp_rdy(resp_rdy), .err_seen(err_seen),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    typedef struct packed {logic [63:0] addr; logic [7:0] len;} ar_t;
    typedef struct packed {logic [63:0] addr; logic last; logic err;} rx_t;

    ar_t ar_exp[$];
    rx_t r_exp[$];
    ar_t s_bursts[$];

    int checks = 0;
    int errors = 0;

    function automatic logic [DATA_W-1:0] pat(input logic [63:0] a);
        return {(DATA_W/64){a ^ 64'hC3C3_0000_5A5A_0000}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic exp_ar(input logic [63:0] a, input logic [7:0] l);
        ar_t e;
        e.addr = a; e.len = l;
        ar_exp.push_back(e);
    endtask

    task automatic exp_r(input logic [63:0] a, input logic last, input logic err);
        rx_t e;
        e.addr = a; e.last = last; e.err = err;
        r_exp.push_back(e);
    endtask

    // slave model
    int          s_beat = 0;
    int          ar_block = 0;
    bit          r_hold = 1'b0;
    bit          rdy_tog = 1'b0;
    logic [63:0] err_addr = '1;
    logic [63:0] s_ba;
    bit          s_arf, s_rf;
    ar_t         s_ar;

    initial begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rid = '0; resp_rdy = 1'b1;
        forever begin
            @(negedge clk);
            s_arf = m_axi_arvalid && m_axi_arready;
            s_rf  = m_axi_rvalid && m_axi_rready;
            s_ar.addr = m_axi_araddr;
            s_ar.len  = m_axi_arlen;
            @(posedge clk); #1;
            if (!rst_n) begin
                s_bursts.delete();
                s_beat = 0;
            end else begin
                if (s_arf) s_bursts.push_back(s_ar);
                if (s_rf && s_bursts.size() > 0) begin
                    if (s_beat == int'(s_bursts[0].len)) begin
                        void'(s_bursts.pop_front());
                        s_beat = 0;
                    end else s_beat++;
                end
            end
            if (m_axi_arvalid && ar_block > 0) ar_block--;
            m_axi_arready = (ar_block == 0);
            resp_rdy = rdy_tog ? ~resp_rdy : 1'b1;
            if (s_bursts.size() > 0 && !r_hold) begin
                s_ba = s_bursts[0].addr + 64'(s_beat) * 64;
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = pat(s_ba);
                m_axi_rlast  = (s_beat == int'(s_bursts[0].len));
                m_axi_rresp  = (s_ba == err_addr) ? 2'b10 : 2'b00;
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
            end
        end
    end

    // monitor
    bit          stall_q = 1'b0;
    logic [63:0] st_addr;
    logic [7:0]  st_len;
    ar_t         m_ar;
    rx_t         m_rx;

    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_q) begin
                chk("ar_stable_valid", 64'(m_axi_arvalid), 64'd1);
                chk("ar_stable_addr", m_axi_araddr, st_addr);
                chk("ar_stable_len", 64'(m_axi_arlen), 64'(st_len));
            end
            stall_q = m_axi_arvalid && !m_axi_arready;
            st_addr = m_axi_araddr;
            st_len  = m_axi_arlen;
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ar_unexpected actual=%0h required=none", m_axi_araddr);
                end else begin
                    m_ar = ar_exp.pop_front();
                    chk("ar_addr", m_axi_araddr, m_ar.addr);
                    chk("ar_len", 64'(m_axi_arlen), 64'(m_ar.len));
                end
            end
            if (resp_val && resp_rdy) begin
                if (r_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected actual=%0h required=none", resp_addr);
                end else begin
                    m_rx = r_exp.pop_front();
                    chk("resp_addr", resp_addr, m_rx.addr);
                    chk("resp_last", 64'(resp_last), 64'(m_rx.last));
                    chk("resp_err", 64'(resp_err), 64'(m_rx.err));
                    checks++;
                    if (resp_data !== pat(m_rx.addr)) begin
                        errors++;
                        $display("FAIL resp_data at %0h actual=%0h required=%0h",
                                 m_rx.addr, resp_data[63:0], pat(m_rx.addr) & 512'hFFFF_FFFF_FFFF_FFFF);
                    end
                end
            end
        end else stall_q = 1'b0;
    end

    task automatic send(input logic [63:0] a, input logic [LEN_W-1:0] l);
        int t;
        t = 0;
        req_addr = a; req_len = l; req_val = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!req_rdy && t < 500);
        if (!req_rdy) begin
            checks++; errors++;
            $display("FAIL req_accept_timeout actual=0 required=1 addr=%0h", a);
        end
        @(posedge clk); #1;
        req_val = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((ar_exp.size() != 0 || r_exp.size() != 0 || s_bursts.size() != 0) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (t >= 2000) begin
            errors++;
            $display("FAIL %s_drain pending_ar=%0d pending_r=%0d required=0",
                     name, ar_exp.size(), r_exp.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_resp_val", 64'(resp_val), 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_err_seen", 64'(err_seen), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_rdy", 64'(req_rdy), 64'd1);
        chk("arsize", 64'(m_axi_arsize), 64'd6);
        chk("arburst", 64'(m_axi_arburst), 64'd1);
        chk("arid", 64'(m_axi_arid), 64'd0);
        @(posedge clk); #1;

        // single line, unaligned address
        exp_ar(64'h40, 8'd0);
        exp_r(64'h40, 1'b1, 1'b0);
        send(64'h48, 5'd1);
        drain("single");

        // 8-line burst
        exp_ar(64'h1_0000, 8'd7);
        for (int i = 0; i < 8; i++) exp_r(64'h1_0000 + 64'(i) * 64'h40, (i == 7), 1'b0);
        send(64'h1_0000, 5'd8);
        drain("burst8");

        // 4 KB split
        exp_ar(64'hFC0, 8'd0);
        exp_ar(64'h1000, 8'd2);
        exp_r(64'hFC0, 1'b0, 1'b0);
        exp_r(64'h1000, 1'b0, 1'b0);
        exp_r(64'h1040, 1'b0, 1'b0);
        exp_r(64'h1080, 1'b1, 1'b0);
        send(64'hFC0, 5'd4);
        drain("split");

        // AR backpressure with toggling resp_rdy
        ar_block = 10;
        rdy_tog = 1'b1;
        @(posedge clk); #1;
        exp_ar(64'h2000, 8'd3);
        for (int i = 0; i < 4; i++) exp_r(64'h2000 + 64'(i) * 64'h40, (i == 3), 1'b0);
        send(64'h2000, 5'd4);
        drain("backpressure");
        rdy_tog = 1'b0;

        // outstanding bursts with R delayed
        r_hold = 1'b1;
        exp_ar(64'h3000, 8'd1);
        exp_ar(64'h4000, 8'd1);
        exp_ar(64'h5000, 8'd1);
        for (int i = 0; i < 2; i++) exp_r(64'h3000 + 64'(i) * 64'h40, (i == 1), 1'b0);
        for (int i = 0; i < 2; i++) exp_r(64'h4000 + 64'(i) * 64'h40, (i == 1), 1'b0);
        for (int i = 0; i < 2; i++) exp_r(64'h5000 + 64'(i) * 64'h40, (i == 1), 1'b0);
        send(64'h3000, 5'd2);
        send(64'h4000, 5'd2);
        repeat (2) @(negedge clk);
        chk("rdy_two_free", 64'(req_rdy), 64'd1);
        @(posedge clk); #1;
        send(64'h5000, 5'd2);
        repeat (3) @(negedge clk);
        chk("rdy_one_free", 64'(req_rdy), 64'd0);
        @(posedge clk); #1;
        r_hold = 1'b0;
        drain("outstanding");
        @(negedge clk);
        chk("rdy_after_drain", 64'(req_rdy), 64'd1);
        @(posedge clk); #1;

        // error on second beat
        err_addr = 64'h6040;
        exp_ar(64'h6000, 8'd2);
        exp_r(64'h6000, 1'b0, 1'b0);
        exp_r(64'h6040, 1'b0, 1'b1);
        exp_r(64'h6080, 1'b1, 1'b0);
        send(64'h6000, 5'd3);
        drain("error");
        err_addr = '1;
        chk("err_seen_set", 64'(err_seen), 64'd1);

        // clamping: len 0 -> 1, len 31 -> MAX_LEN
        exp_ar(64'h7000, 8'd0);
        exp_r(64'h7000, 1'b1, 1'b0);
        send(64'h7000, 5'd0);
        drain("clamp0");
        chk("err_seen_sticky", 64'(err_seen), 64'd1);
        exp_ar(64'h8000, 8'd15);
        for (int i = 0; i < 16; i++) exp_r(64'h8000 + 64'(i) * 64'h40, (i == 15), 1'b0);
        send(64'h8000, 5'd31);
        drain("clampmax");

        rst_n = 1'b0;
        #1;
        chk("rst2_err_seen", 64'(err_seen), 64'd0);
        chk("rst2_req_rdy", 64'(req_rdy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_release_rdy", 64'(req_rdy), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
